// File: rtl/pipe_vect_elastic.sv
// Elastic pipeline stage for the SIMD datapath.
// Carries a control word plus NUM_VECT vector operands under valid/ready.
// A head register (main) drives the outputs and a skid register absorbs the
// one extra beat that can arrive while downstream stalls. This lets in_ready
// come straight from state flops and still sustain one transfer per cycle.
module pipe_vect_elastic #(
  parameter int WIDTH    = 8,
  parameter int REG_SIZE = 16,
  parameter int VEC_SIZE = 4,
  parameter int NUM_VECT = 3
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic                                             flush,
  input  logic                                             in_valid,
  output logic                                             in_ready,
  input  logic [WIDTH-1:0]                                 in_ctrl,
  input  logic [NUM_VECT-1:0][VEC_SIZE-1:0][REG_SIZE-1:0]  in_vect,
  output logic                                             out_valid,
  input  logic                                             out_ready,
  output logic [WIDTH-1:0]                                 out_ctrl,
  output logic [NUM_VECT-1:0][VEC_SIZE-1:0][REG_SIZE-1:0]  out_vect,
  output logic [1:0]                                       occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                                            state;
  logic [WIDTH-1:0]                                  main_ctrl;
  logic [WIDTH-1:0]                                  skid_ctrl;
  logic [NUM_VECT-1:0][VEC_SIZE-1:0][REG_SIZE-1:0]   main_vect;
  logic [NUM_VECT-1:0][VEC_SIZE-1:0][REG_SIZE-1:0]   skid_vect;
  logic                                              push;
  logic                                              pop;

  // Handshake flags are decoded from state only, so out_ready never reaches in_ready.
  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign out_ctrl  = main_ctrl;
  assign out_vect  = main_vect;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  // Occupancy FSM and data movement between input, skid and head registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_vect <= '0;
      skid_vect <= '0;
    end else if (flush) begin
      // Squash drops any incoming beat; a pop this cycle has already been seen downstream.
      state     <= EMPTY;
      main_ctrl <= '0;
      skid_ctrl <= '0;
      main_vect <= '0;
      skid_vect <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state     <= ONE;
            main_ctrl <= in_ctrl;
            main_vect <= in_vect;
          end
        end
        ONE: begin
          if (push && !pop) begin
            state     <= FULL;
            skid_ctrl <= in_ctrl;
            skid_vect <= in_vect;
          end else if (pop && !push) begin
            state <= EMPTY;
          end else if (push && pop) begin
            // Back-to-back beat replaces the head directly, no bubble.
            main_ctrl <= in_ctrl;
            main_vect <= in_vect;
          end
        end
        FULL: begin
          if (pop) begin
            state     <= ONE;
            main_ctrl <= skid_ctrl;
            main_vect <= skid_vect;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_vect_elastic.sv
// Bench for pipe_vect_elastic: directed vector table, streaming, async reset
// and randomized scoreboard runs on two parameterisations.
module tb_pipe_vect_elastic;

  localparam int AW = 8,  AR = 16, AV = 4, AN = 3;
  localparam int BW = 4,  BR = 32, BV = 8, BN = 1;

  typedef logic [AN-1:0][AV-1:0][AR-1:0] va_t;
  typedef logic [BN-1:0][BV-1:0][BR-1:0] vb_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic          a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [AW-1:0] a_in_ctrl, a_out_ctrl;
  va_t           a_in_vect, a_out_vect;
  logic [1:0]    a_occ;

  logic          b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [BW-1:0] b_in_ctrl, b_out_ctrl;
  vb_t           b_in_vect, b_out_vect;
  logic [1:0]    b_occ;

  pipe_vect_elastic #(.WIDTH(AW), .REG_SIZE(AR), .VEC_SIZE(AV), .NUM_VECT(AN)) dut_a (
    .clk(clk), .rst(rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_vect(a_in_vect),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_vect(a_out_vect),
    .occupancy(a_occ)
  );

  pipe_vect_elastic #(.WIDTH(BW), .REG_SIZE(BR), .VEC_SIZE(BV), .NUM_VECT(BN)) dut_b (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_vect(b_in_vect),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_vect(b_out_vect),
    .occupancy(b_occ)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [299:0] act, input logic [299:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // vect k lane j = {k, j, tag}
  function automatic va_t vect_a(input logic [7:0] tag);
    va_t v;
    for (int k = 0; k < AN; k++)
      for (int j = 0; j < AV; j++)
        v[k][j] = {k[3:0], j[3:0], tag};
    return v;
  endfunction

  function automatic vb_t vect_b(input logic [15:0] tag);
    vb_t v;
    for (int k = 0; k < BN; k++)
      for (int j = 0; j < BV; j++)
        v[k][j] = {k[7:0], j[7:0], tag};
    return v;
  endfunction

  typedef struct {
    logic       iv;
    logic [7:0] ctrl;
    logic       ordy;
    logic       fl;
    logic       ov;
    logic [7:0] octrl;
    logic [1:0] occ;
    logic       ir;
    logic       zv;
  } row_t;

  row_t tbl[$];

  task automatic add(input logic iv, input logic [7:0] ctrl, input logic ordy, input logic fl,
                     input logic ov, input logic [7:0] octrl, input logic [1:0] occ,
                     input logic ir, input logic zv);
    row_t r;
    r.iv = iv; r.ctrl = ctrl; r.ordy = ordy; r.fl = fl;
    r.ov = ov; r.octrl = octrl; r.occ = occ; r.ir = ir; r.zv = zv;
    tbl.push_back(r);
  endtask

  logic [AW+AN*AV*AR-1:0] qa[$];
  logic [BW+BN*BV*BR-1:0] qb[$];
  logic [AW-1:0] a_cnt = '0;
  logic [BW-1:0] b_cnt = '0;

  // One randomized cycle on both instances with scoreboard bookkeeping.
  task automatic step_rand(input int cyc, input bit drain);
    logic [AW+AN*AV*AR-1:0] ea;
    logic [BW+BN*BV*BR-1:0] eb;
    @(negedge clk);
    a_in_valid  = drain ? 1'b0 : ($urandom_range(0, 3) != 0);
    a_out_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    a_in_ctrl   = a_cnt;
    a_in_vect   = vect_a(cyc[7:0]);
    b_in_valid  = drain ? 1'b0 : ($urandom_range(0, 2) != 0);
    b_out_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
    b_in_ctrl   = b_cnt;
    b_in_vect   = vect_b(cyc[15:0]);
    #1;
    check("a occ", 300'(a_occ), 300'(qa.size()));
    check("b occ", 300'(b_occ), 300'(qb.size()));
    if (a_out_valid && a_out_ready) begin
      if (qa.size() == 0) check("a pop on empty", 300'(1), 300'(0));
      else begin
        ea = qa.pop_front();
        check("a data", 300'({a_out_ctrl, a_out_vect}), 300'(ea));
      end
    end
    if (a_in_valid && a_in_ready) begin
      qa.push_back({a_in_ctrl, a_in_vect});
      a_cnt++;
    end
    if (b_out_valid && b_out_ready) begin
      if (qb.size() == 0) check("b pop on empty", 300'(1), 300'(0));
      else begin
        eb = qb.pop_front();
        check("b data", 300'({b_out_ctrl, b_out_vect}), 300'(eb));
      end
    end
    if (b_in_valid && b_in_ready) begin
      qb.push_back({b_in_ctrl, b_in_vect});
      b_cnt++;
    end
    @(posedge clk);
  endtask

  initial begin
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_ctrl = '0; a_in_vect = '0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_ctrl = '0; b_in_vect = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst a ov", 300'(a_out_valid), 300'(0));
    check("rst a occ", 300'(a_occ), 300'(0));
    check("rst a ir", 300'(a_in_ready), 300'(1));
    check("rst b ov", 300'(b_out_valid), 300'(0));
    rst = 1'b1;

    // Directed table: drive before the edge, check just after.
    add(1, 8'h01, 1, 0,  1, 8'h01, 1, 1, 0);
    add(1, 8'h02, 1, 0,  1, 8'h02, 1, 1, 0);
    add(1, 8'h03, 1, 0,  1, 8'h03, 1, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'h03, 0, 1, 0);
    add(1, 8'hA1, 0, 0,  1, 8'hA1, 1, 1, 0);
    add(1, 8'hA2, 0, 0,  1, 8'hA1, 2, 0, 0);
    add(1, 8'hA3, 0, 0,  1, 8'hA1, 2, 0, 0);
    add(1, 8'hA3, 1, 0,  1, 8'hA2, 1, 1, 0);
    add(1, 8'hA3, 1, 0,  1, 8'hA3, 1, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'hA3, 0, 1, 0);
    add(1, 8'hB1, 0, 0,  1, 8'hB1, 1, 1, 0);
    add(1, 8'hB2, 0, 0,  1, 8'hB1, 2, 0, 0);
    add(1, 8'h55, 1, 1,  0, 8'h00, 0, 1, 1);
    add(0, 8'h00, 1, 0,  0, 8'h00, 0, 1, 1);
    add(1, 8'hC1, 0, 0,  1, 8'hC1, 1, 1, 0);
    add(1, 8'hC2, 1, 1,  0, 8'h00, 0, 1, 1);
    add(1, 8'hD1, 1, 0,  1, 8'hD1, 1, 1, 0);
    add(0, 8'h00, 0, 0,  1, 8'hD1, 1, 1, 0);
    add(0, 8'h00, 1, 0,  0, 8'hD1, 0, 1, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      a_in_valid  = tbl[i].iv;
      a_in_ctrl   = tbl[i].ctrl;
      a_in_vect   = vect_a(tbl[i].ctrl);
      a_out_ready = tbl[i].ordy;
      a_flush     = tbl[i].fl;
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d ov", i), 300'(a_out_valid), 300'(tbl[i].ov));
      check($sformatf("tbl%0d ctrl", i), 300'(a_out_ctrl), 300'(tbl[i].octrl));
      check($sformatf("tbl%0d occ", i), 300'(a_occ), 300'(tbl[i].occ));
      check($sformatf("tbl%0d ir", i), 300'(a_in_ready), 300'(tbl[i].ir));
      check($sformatf("tbl%0d vect", i), 300'(a_out_vect),
            tbl[i].zv ? 300'(0) : 300'(vect_a(tbl[i].octrl)));
    end
    @(negedge clk);
    a_flush = 0; a_in_valid = 0;

    // Streaming 0x01..0x10 with out_ready held high
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      a_in_valid = 1; a_out_ready = 1;
      a_in_ctrl = 8'(k); a_in_vect = vect_a(8'(k));
      @(posedge clk);
      #1;
      check($sformatf("stream%0d ov", k), 300'(a_out_valid), 300'(1));
      check($sformatf("stream%0d ctrl", k), 300'(a_out_ctrl), 300'(k));
      check($sformatf("stream%0d occ", k), 300'(a_occ), 300'(1));
      check($sformatf("stream%0d vect", k), 300'(a_out_vect), 300'(vect_a(8'(k))));
    end
    @(negedge clk);
    a_in_valid = 0;
    @(posedge clk);
    #1;
    check("stream drain occ", 300'(a_occ), 300'(0));

    // Asynchronous reset while FULL
    @(negedge clk);
    a_in_valid = 1; a_out_ready = 0; a_in_ctrl = 8'hE1; a_in_vect = vect_a(8'hE1);
    @(negedge clk);
    a_in_ctrl = 8'hE2; a_in_vect = vect_a(8'hE2);
    @(negedge clk);
    a_in_valid = 0;
    check("pre-rst occ", 300'(a_occ), 300'(2));
    check("pre-rst ir", 300'(a_in_ready), 300'(0));
    #2;
    rst = 1'b0;
    #1;
    check("arst ov", 300'(a_out_valid), 300'(0));
    check("arst occ", 300'(a_occ), 300'(0));
    check("arst ir", 300'(a_in_ready), 300'(1));
    check("arst ctrl", 300'(a_out_ctrl), 300'(0));
    check("arst vect", 300'(a_out_vect), 300'(0));
    @(negedge clk);
    rst = 1'b1;

    // Randomized scoreboard on both parameterisations
    for (int c = 0; c < 1000; c++) step_rand(c, 1'b0);
    for (int c = 1000; c < 1008; c++) step_rand(c, 1'b1);
    check("a queue empty", 300'(qa.size()), 300'(0));
    check("b queue empty", 300'(qb.size()), 300'(0));
    check("a final ov", 300'(a_out_valid), 300'(0));
    check("b final ov", 300'(b_out_valid), 300'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
